rv32e_frontend: RTL and testbench

RV32E_FRONTEND -- requirements
Module: rv32e_frontend

---
 rtl/rv32e_frontend_pkg.sv | 30 +++
 rtl/rv32e_alu.sv | 35 +++
 rtl/rv32e_frontend.sv | 121 ++++++++++++
 tb/tb_rv32e_frontend.sv | 136 +++++++++++++
 4 files changed

// File: rtl/rv32e_frontend_pkg.sv
// rv32e_frontend_pkg: opcode, branch func3 and ALU operation encodings shared by the frontend.
package rv32e_frontend_pkg;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;
endpackage

// File: rtl/rv32e_alu.sv
// rv32e_alu: combinational RV32 integer ALU with zero and signed/unsigned less-than flags.
module rv32e_alu
    import rv32e_frontend_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  alu_op,
    output logic [31:0] result,
    output logic        zero,
    output logic        less,
    output logic        less_u
);
    logic [4:0] sh;

    assign sh     = b[4:0];
    assign less   = $signed(a) < $signed(b);
    assign less_u = a < b;
    assign zero   = result == 32'h0;

    always_comb begin
        case (alu_op)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_SLL:  result = a << sh;
            ALU_SLT:  result = {31'b0, less};
            ALU_SLTU: result = {31'b0, less_u};
            ALU_XOR:  result = a ^ b;
            ALU_SRL:  result = a >> sh;
            ALU_SRA:  result = 32'($signed(a) >>> sh);
            ALU_OR:   result = a | b;
            ALU_AND:  result = a & b;
            default:  result = 32'h0;
        endcase
    end
endmodule

// File: rtl/rv32e_frontend.sv
// rv32e_frontend: single-cycle fetch/decode/execute front end; pc is the only state.
module rv32e_frontend
    import rv32e_frontend_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic [31:0] rs1_val,
    input  logic [31:0] rs2_val,
    output logic [31:0] pc,
    output logic [31:0] instr,
    output logic [6:0]  opcode,
    output logic [2:0]  func3,
    output logic [6:0]  func7,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic [31:0] imm,
    output logic        reg_write,
    output logic        mem_write,
    output logic        mem_read,
    output logic [3:0]  alu_op,
    output logic [31:0] alu_result,
    output logic        alu_zero,
    output logic        alu_less,
    output logic        take_branch,
    output logic [31:0] next_pc
);
    logic [31:0] pc_q, pc_d, alu_b;
    logic        alu_less_u, is_op, is_br;

    assign pc        = pc_q;
    assign imem_addr = pc_q;
    assign instr     = imem_rdata;
    assign opcode    = instr[6:0];
    assign func3     = instr[14:12];
    assign func7     = instr[31:25];
    assign rs1       = instr[19:15];
    assign rs2       = instr[24:20];
    assign rd        = instr[11:7];
    assign is_op     = opcode == OPC_OP;
    assign is_br     = opcode == OPC_BRANCH;

    always_comb begin
        case (opcode)
            OPC_LOAD, OPC_OP_IMM, OPC_JALR: imm = {{20{instr[31]}}, instr[31:20]};
            OPC_STORE:                      imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            OPC_BRANCH:                     imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:             imm = {instr[31:12], 12'b0};
            OPC_JAL:                        imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            default:                        imm = 32'h0;
        endcase
    end

    assign reg_write = opcode inside {OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_LOAD, OPC_OP, OPC_OP_IMM};
    assign mem_read  = opcode == OPC_LOAD;
    assign mem_write = opcode == OPC_STORE;

    // instr[30] is func7[5]: SUB only for register ops, SRA/SRAI for both
    always_comb begin
        alu_op = ALU_ADD;
        if (is_br)
            alu_op = ALU_SUB;
        else if (is_op || opcode == OPC_OP_IMM)
            case (func3)
                3'b000:  alu_op = (is_op && func7[5]) ? ALU_SUB : ALU_ADD;
                3'b001:  alu_op = ALU_SLL;
                3'b010:  alu_op = ALU_SLT;
                3'b011:  alu_op = ALU_SLTU;
                3'b100:  alu_op = ALU_XOR;
                3'b101:  alu_op = func7[5] ? ALU_SRA : ALU_SRL;
                3'b110:  alu_op = ALU_OR;
                default: alu_op = ALU_AND;
            endcase
    end

    assign alu_b = (is_op || is_br) ? rs2_val : imm;

    rv32e_alu u_alu (
        .a      (rs1_val),
        .b      (alu_b),
        .alu_op (alu_op),
        .result (alu_result),
        .zero   (alu_zero),
        .less   (alu_less),
        .less_u (alu_less_u)
    );

    always_comb begin
        take_branch = 1'b0;
        if (is_br)
            case (func3)
                F3_BEQ:  take_branch = alu_zero;
                F3_BNE:  take_branch = !alu_zero;
                F3_BLT:  take_branch = alu_less;
                F3_BGE:  take_branch = !alu_less;
                F3_BLTU: take_branch = alu_less_u;
                F3_BGEU: take_branch = !alu_less_u;
                default: take_branch = 1'b0;
            endcase
    end

    always_comb begin
        next_pc = pc_q + 32'd4;
        if (opcode == OPC_JAL || take_branch)
            next_pc = pc_q + imm;
        else if (opcode == OPC_JALR && func3 == 3'b000)
            next_pc = (rs1_val + imm) & ~32'h1;
    end

    assign pc_d = next_pc;

    always_ff @(posedge clk or posedge reset)
        if (reset)
            pc_q <= RESET_PC;
        else
            pc_q <= pc_d;
endmodule

// File: tb/tb_rv32e_frontend.sv
// tb_rv32e_frontend: directed vectors with hand-computed expectations for rv32e_frontend.
module tb_rv32e_frontend;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] imem_addr, imem_rdata, rs1_val, rs2_val, pc, instr, imm, alu_result, next_pc;
    logic [6:0]  opcode, func7;
    logic [2:0]  func3;
    logic [4:0]  rs1, rs2, rd;
    logic        reg_write, mem_write, mem_read, alu_zero, alu_less, take_branch;
    logic [3:0]  alu_op;
    int          n_chk = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    rv32e_frontend dut (
        .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .rs1_val(rs1_val), .rs2_val(rs2_val), .pc(pc), .instr(instr),
        .opcode(opcode), .func3(func3), .func7(func7), .rs1(rs1), .rs2(rs2), .rd(rd),
        .imm(imm), .reg_write(reg_write), .mem_write(mem_write), .mem_read(mem_read),
        .alu_op(alu_op), .alu_result(alu_result), .alu_zero(alu_zero), .alu_less(alu_less),
        .take_branch(take_branch), .next_pc(next_pc)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic drive(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
        imem_rdata = i;
        rs1_val = a;
        rs2_val = b;
        #1;
    endtask

    task automatic restart();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    initial begin
        drive(32'h0000_0013, 0, 0);
        repeat (2) @(negedge clk);
        chk("reset_pc", pc, 32'h8000_0000);
        chk("reset_addr", imem_addr, 32'h8000_0000);
        reset = 1'b0;
        #1 chk("first_fetch", pc, 32'h8000_0000);
        @(posedge clk); #1 chk("nop_pc1", pc, 32'h8000_0004);
        @(posedge clk); #1 chk("nop_pc2", pc, 32'h8000_0008);
        chk("nop_next", next_pc, 32'h8000_000C);
        chk("nop_instr", instr, 32'h0000_0013);

        drive(32'hFFF0_0093, 0, 0);
        chk("addi_imm", imm, 32'hFFFF_FFFF);
        chk("addi_op", alu_op, 0);
        chk("addi_res", alu_result, 32'hFFFF_FFFF);
        chk("addi_rw", reg_write, 1);
        chk("addi_rd", rd, 1);
        chk("addi_opcode", opcode, 32'h13);

        drive(32'h4000_0033, 3, 5);
        chk("sub_op", alu_op, 1);
        chk("sub_res", alu_result, 32'hFFFF_FFFE);
        chk("sub_less", alu_less, 1);
        chk("sub_zero", alu_zero, 0);
        chk("sub_func7", func7, 32'h20);

        drive(32'h0020_E463, 32'hFFFF_FFFF, 1);
        chk("bltu_take", take_branch, 0);
        chk("bltu_less", alu_less, 1);
        drive(32'h0020_C463, 32'hFFFF_FFFF, 1);
        chk("blt_take", take_branch, 1);
        drive(32'h0020_F463, 32'hFFFF_FFFF, 1);
        chk("bgeu_take", take_branch, 1);

        drive(32'h0020_A223, 32'h0000_1000, 7);
        chk("sw_imm", imm, 4);
        chk("sw_res", alu_result, 32'h0000_1004);
        chk("sw_mw", mem_write, 1);
        chk("sw_rw", reg_write, 0);
        chk("sw_rs2", rs2, 2);

        drive(32'hFFC0_A183, 32'h0000_1000, 0);
        chk("lw_imm", imm, 32'hFFFF_FFFC);
        chk("lw_mr", mem_read, 1);
        chk("lw_res", alu_result, 32'h0000_0FFC);
        chk("lw_func3", func3, 2);

        drive(32'h1234_52B7, 0, 0);
        chk("lui_imm", imm, 32'h1234_5000);
        chk("lui_rw", reg_write, 1);

        drive(32'h4040_D093, 32'h8000_0000, 0);
        chk("srai_op", alu_op, 7);
        chk("srai_res", alu_result, 32'hF800_0000);

        drive(32'hFFFF_FFFF, 1, 2);
        chk("unk_imm", imm, 0);
        chk("unk_ctl", {reg_write, mem_read, mem_write}, 0);

        restart();
        drive(32'h0020_8463, 5, 6);
        chk("beq_nt", take_branch, 0);
        chk("beq_nt_next", next_pc, 32'h8000_0004);
        drive(32'h0020_8463, 5, 5);
        chk("beq_t", take_branch, 1);
        chk("beq_t_next", next_pc, 32'h8000_0008);
        @(posedge clk); #1 chk("beq_pc", pc, 32'h8000_0008);

        drive(32'h0000_0013, 0, 0);
        repeat (2) @(posedge clk);
        #1 chk("pre_jal_pc", pc, 32'h8000_0010);
        drive(32'h0000_006F, 0, 0);
        chk("jal_next", next_pc, 32'h8000_0010);
        @(posedge clk); #1 chk("jal_pc", pc, 32'h8000_0010);
        drive(32'h0010_8067, 32'h8000_0100, 0);
        chk("jalr_next", next_pc, 32'h8000_0100);
        chk("jalr_rw", reg_write, 1);

        drive(32'h0000_006F, 0, 0);
        @(negedge clk);
        #2 reset = 1'b1;
        #1 chk("async_reset_pc", pc, 32'h8000_0000);
        chk("async_clk_low", clk, 0);
        @(negedge clk);
        reset = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
